// File: rtl/icache_refill_if.sv
// Wishbone classic read port between the icache refill engine (master)
// and the memory side (slave).
//
// Handshake: a beat is offered while wb_cyc_o && wb_stb_o are high, with
// wb_adr_o held stable. It completes on the clock edge where the slave
// returns wb_ack_i (data on wb_dat_i) or wb_err_i. The master may change
// the address only after that edge. wb_err_i takes priority over wb_ack_i.
interface icache_refill_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/icache_refill.sv
// icache miss handler: on a fetch miss, reads the 128-bit pack as four
// 32-bit Wishbone classic reads, then strobes it into icache for one cycle.
// Bus errors and per-beat timeouts abort the refill and raise a fault pulse.
module icache_refill #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                rst,
  input  logic [27:0]         curr_PC,
  input  logic                fetch_valid,
  input  logic                cache_hit,
  input  logic                flush,
  output logic [127:0]        new_entry,
  output logic                entry_valid,
  output logic                busy,
  output logic                fault,
  output logic [27:0]         fault_addr,
  output logic [1:0]          dbg_state,
  icache_refill_if.master     wb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last timer value tolerated on one beat before it counts as a timeout.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [27:0] pc_q;
  logic [1:0]  idx;
  logic [7:0]  timer;
  logic        cyc_q;
  logic        stb_q;
  logic [31:0] adr_q;

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = 4'hF;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Refill FSM: all bus and icache-facing outputs are registered here.
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_q        <= '0;
      idx         <= '0;
      timer       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      adr_q       <= '0;
      new_entry   <= '0;
      entry_valid <= 1'b0;
      fault       <= 1'b0;
      fault_addr  <= '0;
    end else begin
      entry_valid <= 1'b0;
      fault       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_valid && !cache_hit && !flush) begin
            pc_q  <= curr_PC;
            idx   <= 2'd0;
            timer <= 8'd0;
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            adr_q <= {curr_PC, 4'h0};
            state <= S_READ;
          end
        end
        S_READ: begin
          if (flush) begin
            // Redirect: drop the bus, any same-cycle data is discarded.
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            state <= S_IDLE;
          end else if (wb.wb_err_i) begin
            fault      <= 1'b1;
            fault_addr <= pc_q;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            state      <= S_IDLE;
          end else if (wb.wb_ack_i) begin
            new_entry[{idx, 5'd0} +: 32] <= wb.wb_dat_i;
            timer <= 8'd0;
            if (idx == 2'd3) begin
              cyc_q <= 1'b0;
              stb_q <= 1'b0;
              state <= S_DONE;
            end else begin
              idx   <= idx + 2'd1;
              adr_q <= {pc_q, idx + 2'd1, 2'b00};
            end
          end else if (timer == TMO_LAST) begin
            fault      <= 1'b1;
            fault_addr <= pc_q;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            state      <= S_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_DONE: begin
          // icache tags with the live curr_PC, so only write if it still matches.
          entry_valid <= (curr_PC == pc_q) && !flush;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill with a Wishbone slave model that has
// configurable wait states, error beat, never-ack mode and address-as-data.
module tb_icache_refill;

  logic         clk;
  logic         rst;
  logic [27:0]  curr_PC;
  logic         fetch_valid;
  logic         cache_hit;
  logic         flush;
  logic [127:0] new_entry;
  logic         entry_valid;
  logic         busy;
  logic         fault;
  logic [27:0]  fault_addr;
  logic [1:0]   dbg_state;

  icache_refill_if wb_if ();

  icache_refill #(.TIMEOUT(8)) dut (
    .wb_clk_i    (clk),
    .rst         (rst),
    .curr_PC     (curr_PC),
    .fetch_valid (fetch_valid),
    .cache_hit   (cache_hit),
    .flush       (flush),
    .new_entry   (new_entry),
    .entry_valid (entry_valid),
    .busy        (busy),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .dbg_state   (dbg_state),
    .wb          (wb_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave model and address scoreboard
  logic [31:0] exp_q[$];
  int  slv_waits = 0;
  int  slv_err_beat = -1;
  bit  slv_noack = 1'b0;
  bit  slv_adr_data = 1'b0;
  int  slv_wcnt = 0;
  int  ack_count = 0;

  initial begin
    wb_if.wb_ack_i = 1'b0;
    wb_if.wb_err_i = 1'b0;
    wb_if.wb_dat_i = '0;
  end

  always @(negedge clk) begin
    if (wb_if.wb_ack_i) begin
      ack_count++;
      slv_wcnt = 0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (wb_if.wb_err_i) slv_wcnt = 0;
    wb_if.wb_ack_i = 1'b0;
    wb_if.wb_err_i = 1'b0;
    if (wb_if.wb_cyc_o && wb_if.wb_stb_o) begin
      if (exp_q.size() > 0) chk("wb_adr", {96'd0, wb_if.wb_adr_o}, {96'd0, exp_q[0]});
      if (!slv_noack) begin
        if (slv_wcnt == slv_waits) begin
          if (slv_err_beat == int'(wb_if.wb_adr_o[3:2])) begin
            wb_if.wb_err_i = 1'b1;
          end else begin
            wb_if.wb_ack_i = 1'b1;
            wb_if.wb_dat_i = slv_adr_data ? wb_if.wb_adr_o
                           : 32'h11111111 * {30'd0, wb_if.wb_adr_o[3:2]} + 32'h11111111;
          end
        end else begin
          slv_wcnt++;
        end
      end
    end else begin
      slv_wcnt = 0;
    end
  end

  // Driver tasks
  int ev_k, ev_n, flt_k, flt_n;
  logic flt_cyc, flt_busy, flush_cyc;

  task automatic push_pack_addrs(input logic [27:0] pc);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({pc, 4'h0} + 32'(4 * i));
  endtask

  // Presents a miss for one edge (edge N), then runs `budget` more edges,
  // optionally pulsing flush on edge N+flush_at and changing curr_PC from
  // edge N+pc_chg_at on.
  task automatic run_refill(input logic [27:0] pc, input int budget, input int flush_at,
                            input int pc_chg_at, input logic [27:0] pc_new);
    ev_k = -1; ev_n = 0; flt_k = -1; flt_n = 0;
    flt_cyc = 1'bx; flt_busy = 1'bx; flush_cyc = 1'bx;
    ack_count = 0;
    @(negedge clk);
    curr_PC = pc; fetch_valid = 1'b1; cache_hit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    fetch_valid = 1'b0;
    chk("cyc_after_miss", {127'd0, wb_if.wb_cyc_o}, 128'd1);
    chk("busy_after_miss", {127'd0, busy}, 128'd1);
    if (flush_at == 1) flush = 1'b1;
    if (pc_chg_at == 1) curr_PC = pc_new;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (entry_valid) begin
        ev_n++;
        if (ev_k < 0) ev_k = k;
      end
      if (fault) begin
        flt_n++;
        if (flt_k < 0) begin
          flt_k = k; flt_cyc = wb_if.wb_cyc_o; flt_busy = busy;
        end
      end
      if (k == flush_at) flush_cyc = wb_if.wb_cyc_o;
      flush = (k + 1 == flush_at);
      if (k + 1 == pc_chg_at) curr_PC = pc_new;
    end
  endtask

  initial begin
    rst = 1'b1; curr_PC = '0; fetch_valid = 1'b0; cache_hit = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", {127'd0, wb_if.wb_cyc_o}, 128'd0);
    chk("rst_stb", {127'd0, wb_if.wb_stb_o}, 128'd0);
    chk("rst_adr", {96'd0, wb_if.wb_adr_o}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_entry_valid", {127'd0, entry_valid}, 128'd0);
    chk("rst_fault", {127'd0, fault}, 128'd0);
    chk("rst_new_entry", new_entry, 128'd0);
    chk("rst_fault_addr", {100'd0, fault_addr}, 128'd0);
    chk("rst_state", {126'd0, dbg_state}, 128'd0);
    chk("we_const", {127'd0, wb_if.wb_we_o}, 128'd0);
    chk("sel_const", {124'd0, wb_if.wb_sel_o}, 128'hF);
    rst = 1'b0;

    // Zero-wait refill of PC 0x0000010
    slv_waits = 0; slv_adr_data = 1'b0;
    push_pack_addrs(28'h0000010);
    run_refill(28'h0000010, 30, -1, -1, '0);
    chk("zw_latency", 128'(ev_k), 128'd5);
    chk("zw_ev_count", 128'(ev_n), 128'd1);
    chk("zw_pack", new_entry, 128'h44444444_33333333_22222222_11111111);
    chk("zw_acks", 128'(ack_count), 128'd4);
    chk("zw_busy_end", {127'd0, busy}, 128'd0);
    chk("zw_adr_q_drained", 128'(exp_q.size()), 128'd0);

    // Three wait states per beat, address returned as data
    slv_waits = 3; slv_adr_data = 1'b1;
    push_pack_addrs(28'h0000234);
    run_refill(28'h0000234, 30, -1, -1, '0);
    chk("ws_latency", 128'(ev_k), 128'd17);
    chk("ws_pack", new_entry, 128'h0000234C_00002348_00002344_00002340);
    chk("ws_acks", 128'(ack_count), 128'd4);
    chk("ws_fault_count", 128'(flt_n), 128'd0);

    // Bus error on beat 2
    slv_waits = 0; slv_adr_data = 1'b0; slv_err_beat = 2;
    push_pack_addrs(28'hABCDEF0);
    run_refill(28'hABCDEF0, 20, -1, -1, '0);
    exp_q.delete(); slv_err_beat = -1;
    chk("err_fault_cycle", 128'(flt_k), 128'd3);
    chk("err_fault_pulses", 128'(flt_n), 128'd1);
    chk("err_fault_addr", {100'd0, fault_addr}, {100'd0, 28'hABCDEF0});
    chk("err_cyc_low", {127'd0, flt_cyc}, 128'd0);
    chk("err_busy_low", {127'd0, flt_busy}, 128'd0);
    chk("err_no_entry", 128'(ev_n), 128'd0);

    // Slave never acks: timeout after 8 cycles of strobe
    slv_noack = 1'b1;
    exp_q.delete(); exp_q.push_back(32'h00000550);
    run_refill(28'h0000055, 20, -1, -1, '0);
    exp_q.delete(); slv_noack = 1'b0;
    chk("tmo_fault_cycle", 128'(flt_k), 128'd8);
    chk("tmo_fault_pulses", 128'(flt_n), 128'd1);
    chk("tmo_fault_addr", {100'd0, fault_addr}, {100'd0, 28'h0000055});
    chk("tmo_no_entry", 128'(ev_n), 128'd0);

    // Next miss restarts from beat 0
    push_pack_addrs(28'h0000066);
    run_refill(28'h0000066, 20, -1, -1, '0);
    chk("restart_latency", 128'(ev_k), 128'd5);
    chk("restart_pack", new_entry, 128'h44444444_33333333_22222222_11111111);
    chk("restart_fault_addr_held", {100'd0, fault_addr}, {100'd0, 28'h0000055});

    // Flush while waiting on beat 1
    slv_waits = 3;
    push_pack_addrs(28'h0000077);
    run_refill(28'h0000077, 20, 6, -1, '0);
    exp_q.delete();
    chk("flush_cyc_low", {127'd0, flush_cyc}, 128'd0);
    chk("flush_no_entry", 128'(ev_n), 128'd0);
    chk("flush_no_fault", 128'(flt_n), 128'd0);
    chk("flush_acks", 128'(ack_count), 128'd1);
    chk("flush_busy_end", {127'd0, busy}, 128'd0);

    // curr_PC moves away before DONE
    slv_waits = 0;
    push_pack_addrs(28'h0000088);
    run_refill(28'h0000088, 20, -1, 3, 28'h0000099);
    chk("pcchg_no_entry", 128'(ev_n), 128'd0);
    chk("pcchg_acks", 128'(ack_count), 128'd4);
    chk("pcchg_busy_end", {127'd0, busy}, 128'd0);

    // Reset in the middle of a beat
    slv_waits = 3;
    exp_q.delete(); exp_q.push_back(32'h00000AA0);
    @(negedge clk);
    curr_PC = 28'h00000AA; fetch_valid = 1'b1; cache_hit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    fetch_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cyc", {127'd0, wb_if.wb_cyc_o}, 128'd0);
    chk("mid_rst_stb", {127'd0, wb_if.wb_stb_o}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_adr", {96'd0, wb_if.wb_adr_o}, 128'd0);
    chk("mid_rst_new_entry", new_entry, 128'd0);
    chk("mid_rst_fault_addr", {100'd0, fault_addr}, 128'd0);
    chk("mid_rst_state", {126'd0, dbg_state}, 128'd0);
    rst = 1'b0;
    exp_q.delete();

    // Hit: no bus activity
    begin
      int cyc_seen;
      cyc_seen = 0;
      curr_PC = 28'h00000BB; fetch_valid = 1'b1; cache_hit = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (wb_if.wb_cyc_o || busy) cyc_seen++;
      end
      fetch_valid = 1'b0;
      chk("hit_no_bus", 128'(cyc_seen), 128'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
